// File: rtl/decode_execute.sv
// Decode/execute stage of the 4-bit processor: two-phase FETCH/EXEC sequencer, accumulator, C/Z flags and output port.
// Optional HALT on opcode F when DECODE_HALT_EN is defined; otherwise opcode F is a NOP.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | fetch register loads ROM[PC], PC increments
// ST_EXEC  | instr/oprnd valid, program_byte is the byte after the opcode
// ST_HALT  | frozen until reset (only with DECODE_HALT_EN)
module decode_execute #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [3:0]        instr_i,
   input  logic [DATA_W-1:0] oprnd_i,
   input  logic [7:0]        program_byte_i,
   input  logic [DATA_W-1:0] in_port_i,
   output logic              fetch_en_o,
   output logic              pc_en_o,
   output logic              pc_load_o,
   output logic [ADDR_W-1:0] load_addr_o,
   output logic [DATA_W-1:0] accu_o,
   output logic              flag_c_o,
   output logic              flag_z_o,
   output logic [DATA_W-1:0] out_port_o,
   output logic              phase_o
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
`ifdef DECODE_HALT_EN
   localparam logic [1:0] ST_HALT  = 2'd2;
`endif

   localparam logic [3:0] OP_LIT  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_NAND = 4'h4;
   localparam logic [3:0] OP_CMP  = 4'h5;
   localparam logic [3:0] OP_IN   = 4'h6;
   localparam logic [3:0] OP_OUT  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JC   = 4'h9;
   localparam logic [3:0] OP_JNC  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JNZ  = 4'hC;
`ifdef DECODE_HALT_EN
   localparam logic [3:0] OP_HLT  = 4'hF;
`endif

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] accu_q, accu_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic [DATA_W-1:0] out_q, out_d;

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] nand_res;
   logic              is_jump;
   logic              take;
   logic              fetch_en, pc_en, pc_load;

   assign sum      = {1'b0, accu_q} + {1'b0, oprnd_i};
   assign diff     = {1'b0, accu_q} - {1'b0, oprnd_i};
   assign nand_res = ~(accu_q & oprnd_i);

   always_comb begin
      is_jump = 1'b1;
      take    = 1'b0;
      case (instr_i)
         OP_JMP:  take = 1'b1;
         OP_JC:   take = c_q;
         OP_JNC:  take = ~c_q;
         OP_JZ:   take = z_q;
         OP_JNZ:  take = ~z_q;
         default: is_jump = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      accu_d   = accu_q;
      c_d      = c_q;
      z_d      = z_q;
      out_d    = out_q;
      fetch_en = 1'b0;
      pc_en    = 1'b0;
      pc_load  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            fetch_en = 1'b1;
            pc_en    = 1'b1;
            state_d  = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            case (instr_i)
               OP_LIT: begin
                  accu_d = oprnd_i;
                  z_d    = (oprnd_i == '0);
               end
               OP_ADD: begin
                  accu_d = sum[DATA_W-1:0];
                  c_d    = sum[DATA_W];
                  z_d    = (sum[DATA_W-1:0] == '0);
               end
               OP_SUB: begin
                  accu_d = diff[DATA_W-1:0];
                  c_d    = diff[DATA_W];
                  z_d    = (diff[DATA_W-1:0] == '0);
               end
               OP_NAND: begin
                  accu_d = nand_res;
                  z_d    = (nand_res == '0);
               end
               OP_CMP: begin
                  c_d = diff[DATA_W];
                  z_d = (diff[DATA_W-1:0] == '0);
               end
               OP_IN: begin
                  accu_d = in_port_i;
                  z_d    = (in_port_i == '0);
               end
               OP_OUT: out_d = accu_q;
`ifdef DECODE_HALT_EN
               OP_HLT: state_d = ST_HALT;
`endif
               default: ;
            endcase
            // a not-taken jump still has to step over its address byte
            if (is_jump) begin
               pc_load = take;
               pc_en   = ~take;
            end
         end
`ifdef DECODE_HALT_EN
         ST_HALT: state_d = ST_HALT;
`endif
         default: state_d = ST_FETCH;
      endcase
      if (reset_i) begin
         fetch_en = 1'b0;
         pc_en    = 1'b0;
         pc_load  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_FETCH;
         accu_q  <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         accu_q  <= accu_d;
         c_q     <= c_d;
         z_q     <= z_d;
         out_q   <= out_d;
      end
   end

   assign fetch_en_o  = fetch_en;
   assign pc_en_o     = pc_en;
   assign pc_load_o   = pc_load;
   assign load_addr_o = {oprnd_i, program_byte_i};
   assign accu_o      = accu_q;
   assign flag_c_o    = c_q;
   assign flag_z_o    = z_q;
   assign out_port_o  = out_q;
   assign phase_o     = (state_q != ST_FETCH);

endmodule

// File: doc/decode_execute.md
Name: decode_execute

Overview:
- Control/execute stage directly downstream of the fetch register in the 4-bit processor.
- Consumes the fetched instr/oprnd nibbles plus the raw program byte from program ROM.
- Drives the program counter's enable/load and the fetch register's enable.
- Holds the 4-bit accumulator, the C/Z flags and a 4-bit output port; two-phase FSM (fetch, execute), one instruction per two clocks.

Parameters:
- ADDR_W, 12, program counter / jump address width; jump target = {oprnd, program_byte}, must equal 12.
- DATA_W, 4, accumulator, operand and I/O width; fixed at 4.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instr  in  4  opcode from fetch register
- oprnd  in  4  operand from fetch register
- program_byte  in  8  current ROM output at PC; second byte of jumps
- in_port  in  4  external input nibble
- fetch_en  out  1  enable for fetch register
- pc_en  out  1  PC increment enable
- pc_load  out  1  PC parallel load
- load_addr  out  12  PC load value
- accu  out  4  accumulator
- flag_c  out  1  carry/borrow flag
- flag_z  out  1  zero flag
- out_port  out  4  registered output nibble
- phase  out  1  0 = FETCH, 1 = EXEC

Behaviour:
- Reset (async, any state, mid-instruction included):
  - state = FETCH; accu = 0; flag_c = 0; flag_z = 0; out_port = 0.
  - fetch_en, pc_en and pc_load forced 0 while reset is high.
- Control outputs are combinational from state, instr, flags and program_byte. pc_en and pc_load are never both 1.
- FETCH:
  - fetch_en = 1, pc_en = 1, pc_load = 0.
  - Edge: fetch register captures ROM[PC], PC increments, state -> EXEC.
- EXEC: fetch_en = 0; instr/oprnd valid; program_byte = ROM[PC] (byte after opcode). Edge: execute, state -> FETCH.
- Opcodes, all 4-bit arithmetic mod 16:
  - 0 NOP: no change.
  - 1 LIT: accu <= oprnd; Z updated.
  - 2 ADD: {C, accu} <= accu + oprnd (5-bit sum); Z = result == 0.
  - 3 SUB: accu <= accu - oprnd; C = 1 if borrow (accu < oprnd); Z updated.
  - 4 NAND: accu <= ~(accu & oprnd); Z updated; C unchanged.
  - 5 CMP: flags as SUB; accu unchanged.
  - 6 IN: accu <= in_port, sampled at the EXEC edge; Z updated.
  - 7 OUT: out_port <= accu.
  - 8 JMP: pc_load = 1; load_addr = {oprnd, program_byte}.
  - 9 JC / A JNC / B JZ / C JNZ:
    - Taken: same as JMP.
    - Not taken: pc_en = 1 to skip the second byte.
    - Condition uses flags as they stand at start of EXEC.
  - D, E: NOP.
  - F: see Optional Feature.
- Jumps never modify accu or flags; the second byte is never fetched as an opcode.
- PC wrap: 0xFFF + 1 -> 0x000 (owned by PC; this block does not special-case it).
- Flag updates happen only in EXEC; in FETCH all datapath registers hold.

Optional Feature:
- Macro DECODE_HALT_EN.
- Defined:
  - Opcode F enters HALT. HALT outputs: fetch_en = pc_en = pc_load = 0; phase = 1.
  - accu, flags and out_port hold; only reset exits HALT.
- Undefined: opcode F behaves as NOP; no HALT state exists.

Test Plan:
- Reset: assert reset mid-EXEC with accu = 0x7 -> same cycle accu = 0, flags = 0, out_port = 0, all control outputs 0; after release, first cycle phase = 0, fetch_en = 1, pc_en = 1.
- Arithmetic: LIT 9, ADD 8 -> accu = 0x1, C = 1, Z = 0. Then SUB 1 -> accu = 0, C = 0, Z = 1. Then SUB 1 -> accu = 0xF, C = 1.
- Jumps: JMP with oprnd = 0x3, program_byte = 0x45 -> pc_load = 1, load_addr = 0x345, pc_en = 0 in that EXEC cycle. JZ with Z = 0 -> pc_load = 0, pc_en = 1 (PC +2 total).
- I/O: in_port = 0xA, IN, OUT -> out_port = 0xA on the EXEC edge of OUT. CMP 0xA -> Z = 1, accu still 0xA.
- Halt: with DECODE_HALT_EN, opcode F -> fetch_en/pc_en stay 0 for 20 cycles, accu held. Without DECODE_HALT_EN -> next FETCH proceeds normally.
- Phase alternation: 10 NOPs -> phase toggles every cycle, PC advances exactly once per 2 clocks.
